fft_input_framer: RTL
=====================

Name: fft_input_framer

Overview:
- Upstream stage of FFT_wrapper (8-point, 16-bit complex).
- Accepts a serial stream of complex samples on a valid/ready handshake and assembles them into 8-sample frames in a ping-pong buffer.
- Presents each completed frame on parallel buses, pulses write and then start to the FFT, and waits for the FFT's ready before it issues the next frame.
- The second bank fills while the FFT is busy, so the input stream stalls only when both banks are occupied.

Parameters:
- N, 8, samples per frame (power of two, 2..64).
- W, 16, bits per real/imag component (two's complement).
- LOG2N, 3, index width (must equal log2(N)).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  framer can accept a sample this cycle.
- s_real  in  W  sample real part.
- s_imag  in  W  sample imaginary part.
- flush  in  1  one-cycle request to zero-pad and issue a partial frame.
- frame_real  out  N*W  slot k occupies bits [k*W +: W]; drives in0_real..in7_real.
- frame_imag  out  N*W  same layout for imaginary parts.
- fft_write  out  1  one-cycle pulse; FFT latches the frame buses.
- fft_start  out  1  one-cycle pulse; FFT begins the transform.
- fft_ready  in  1  FFT result valid / FFT idle.
- frame_cnt  out  16  number of frames issued, wraps at 2^16.

Behaviour:
- Reset values:
  - s_ready = 0, fft_write = 0, fft_start = 0, frame_cnt = 0.
  - frame_real = 0, frame_imag = 0.
  - Both banks empty, fill pointer = 0, bank select = 0, FSM = IDLE.
- s_ready is registered:
  - Rises on the first clock edge after RST_N deasserts.
  - s_ready = 1 iff the fill bank holds fewer than N samples.
- Sample acceptance:
  - A transfer occurs on a rising edge where s_valid & s_ready.
  - The sample is stored at slot wr_idx of the fill bank, then wr_idx increments.
  - wr_idx wraps N-1 -> 0 and marks the fill bank full.
  - When the last accepted sample fills the bank, s_ready drops on the same edge, so no sample N+1 is taken.
- FSM states: IDLE, WRITE, START, WAIT.
  - IDLE -> WRITE when a full bank exists.
    - The full bank becomes the output bank and is copied to frame_real/frame_imag.
    - The other bank becomes the fill bank, and s_ready re-asserts next cycle if that bank is empty.
  - WRITE:
    - fft_write = 1 for exactly one cycle.
    - The frame buses are stable from the WRITE cycle until the next IDLE -> WRITE transition.
  - START:
    - fft_start = 1 for exactly one cycle.
    - frame_cnt increments on this cycle.
  - WAIT:
    - fft_ready is ignored in the first WAIT cycle.
    - Thereafter, fft_ready = 1 -> IDLE.
  - IDLE with the fill bank already full: -> WRITE on the next edge, giving back-to-back frames with no bubble.
- Latency:
  - Last sample accepted at edge t.
  - fft_write high in cycle t+1, fft_start high in cycle t+2, earliest WAIT exit at t+4.
- Both banks full: s_ready = 0 until WAIT -> IDLE, then normal swap.
- Flush:
  - Sampled only in FILL with 0 < wr_idx < N.
  - Remaining slots are zero-filled and the bank is marked full at the same edge.
  - A flush with wr_idx = 0 is ignored, producing no frame.
  - flush coincident with an accepted sample: the sample is stored first, then padding is applied.
- Reset mid-operation: all state returns to reset values immediately; partial frames are discarded and no write/start pulse is emitted.
- Arithmetic: samples are stored bit-exact with no scaling. frame_cnt wraps modulo 2^16.

Optional Feature:
- Macro FFT_IN_BITREV_EN.
  - Defined: sample index i is stored at slot bitrev_LOG2N(i). For N=8, stream order 0..7 lands in slots 0,4,2,6,1,5,3,7, giving a DIT core its natural input order.
  - Undefined: sample i goes to slot i.
- Flush zero-padding applies to the remaining logical indices in either mode.

Decomposition:
- Package fft_pkg:
  - Constants FFT_N=8, FFT_W=16, FFT_LOG2N=3.
  - Typedef cplx_t {signed [W-1:0] re, im}.
  - FSM state enum.
  - Function bitrev(idx).
- One sub-module, fft_frame_bank: a single N-slot complex register bank with write-enable, slot address, zero-clear, full flag and a flattened read bus. It is instantiated twice for ping-pong.

Test Plan:
- After reset, stream 50,50,50,50,0,0,0,0 (imag 0) with s_valid held high:
  - fft_write at t+1 with frame_real slots = {50,50,50,50,0,0,0,0}.
  - fft_start at t+2; frame_cnt = 1.
- FFT_IN_BITREV_EN defined, stream real 0..7:
  - frame_real slots = {0,4,2,6,1,5,3,7}.
- Back-to-back frames with fft_ready held low for 20 cycles after start:
  - The second frame's 8 samples are accepted.
  - s_ready = 0 after the 8th sample until fft_ready is seen.
  - Second fft_write occurs the cycle after WAIT -> IDLE.
  - The first frame's buses stay unchanged throughout.
- Stream 3 samples (7,8,9), then pulse flush:
  - Frame slots = {7,8,9,0,0,0,0,0} and one write/start pair.
  - flush with no samples pending produces no pulse.
- Assert RST_N low after 5 samples of a frame:
  - All outputs return to 0 asynchronously and s_ready = 0 during reset.
  - After release, 8 new samples produce a frame containing only the new data.
- Hold s_valid low for 10 cycles in mid-frame:
  - No spurious write/start.
  - The frame completes correctly once streaming resumes.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type, FSM encoding and index bit-reversal for the FFT input framer.
package fft_pkg;

   localparam int FFT_N     = 8;
   localparam int FFT_W     = 16;
   localparam int FFT_LOG2N = 3;

   typedef struct packed {
      logic signed [FFT_W-1:0] re;
      logic signed [FFT_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_START,
      ST_WAIT
   } state_t;

   function automatic int bitrev(input int idx, input int bits);
      int r;
      r = 0;
      for (int b = 0; b < 32; b++) begin
         if (b < bits) r[bits-1-b] = idx[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-slot complex sample bank: addressed write, per-slot zero clear, full flag, flat read bus.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int N     = FFT_N,
   parameter int W     = FFT_W,
   parameter int LOG2N = FFT_LOG2N
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             we,
   input  logic [LOG2N-1:0] waddr,
   input  logic [W-1:0]     wr_real,
   input  logic [W-1:0]     wr_imag,
   input  logic [N-1:0]     clr_mask,
   input  logic             set_full,
   input  logic             clr_full,
   output logic             full,
   output logic [N*W-1:0]   rd_real,
   output logic [N*W-1:0]   rd_imag
);

   logic signed [W-1:0] mem_re [N];
   logic signed [W-1:0] mem_im [N];

   // Sample storage is data only; emptiness is tracked by the full flag and write index.
   always_ff @(posedge CLK) begin
      for (int k = 0; k < N; k++) begin
         if (clr_mask[k]) begin
            mem_re[k] <= '0;
            mem_im[k] <= '0;
         end else if (we && (waddr == LOG2N'(k))) begin
            mem_re[k] <= wr_real;
            mem_im[k] <= wr_imag;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)        full <= 1'b0;
      else if (set_full) full <= 1'b1;
      else if (clr_full) full <= 1'b0;
   end

   for (genvar k = 0; k < N; k++) begin : g_rd
      assign rd_real[k*W +: W] = mem_re[k];
      assign rd_imag[k*W +: W] = mem_im[k];
   end

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-frame ping-pong framer feeding an N-point FFT with write/start handshake.
// Define FFT_IN_BITREV_EN to store stream index i at slot bitrev(i) for a DIT core.
module fft_input_framer
   import fft_pkg::*;
#(
   parameter int N     = FFT_N,
   parameter int W     = FFT_W,
   parameter int LOG2N = FFT_LOG2N
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_real,
   input  logic [W-1:0]   s_imag,
   input  logic           flush,
   output logic [N*W-1:0] frame_real,
   output logic [N*W-1:0] frame_imag,
   output logic           fft_write,
   output logic           fft_start,
   input  logic           fft_ready,
   output logic [15:0]    frame_cnt
);

   state_t           state;
   logic             wait_first;
   logic             fill_sel;
   logic [LOG2N-1:0] wr_idx;
   logic             full0, full1;
   logic [N*W-1:0]   rd_re0, rd_im0, rd_re1, rd_im1;
   cplx_t            samp;

   logic             accept, last, fill_full, flush_eff, swap, wait_exit;
   logic [LOG2N:0]   nidx;
   logic [N-1:0]     pad_mask;
   logic [LOG2N-1:0] wslot;

   function automatic logic [LOG2N-1:0] slot_of(input int idx);
`ifdef FFT_IN_BITREV_EN
      return LOG2N'(bitrev(idx, LOG2N));
`else
      return LOG2N'(idx);
`endif
   endfunction

   assign samp = '{re: s_real, im: s_imag};

   always_comb begin
      accept    = s_valid & s_ready;
      fill_full = fill_sel ? full1 : full0;
      last      = accept && (wr_idx == LOG2N'(N-1));
      nidx      = {1'b0, wr_idx} + {{LOG2N{1'b0}}, accept};
      // A flush only counts if at least one sample (including one taken this edge) is pending.
      flush_eff = flush && !fill_full && !last && (nidx != '0);
      swap      = (state == ST_IDLE) && fill_full;
      wait_exit = (state == ST_WAIT) && !wait_first && fft_ready;
      wslot     = slot_of(int'(wr_idx));
      pad_mask  = '0;
      for (int j = 0; j < N; j++) begin
         if ((LOG2N+1)'(j) >= nidx) pad_mask[slot_of(j)] = 1'b1;
      end
   end

   fft_frame_bank #(.N(N), .W(W), .LOG2N(LOG2N)) u_bank0 (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .we       (accept && !fill_sel),
      .waddr    (wslot),
      .wr_real  (samp.re),
      .wr_imag  (samp.im),
      .clr_mask ((flush_eff && !fill_sel) ? pad_mask : '0),
      .set_full ((last || flush_eff) && !fill_sel),
      .clr_full (wait_exit && fill_sel),
      .full     (full0),
      .rd_real  (rd_re0),
      .rd_imag  (rd_im0)
   );

   fft_frame_bank #(.N(N), .W(W), .LOG2N(LOG2N)) u_bank1 (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .we       (accept && fill_sel),
      .waddr    (wslot),
      .wr_real  (samp.re),
      .wr_imag  (samp.im),
      .clr_mask ((flush_eff && fill_sel) ? pad_mask : '0),
      .set_full ((last || flush_eff) && fill_sel),
      .clr_full (wait_exit && !fill_sel),
      .full     (full1),
      .rd_real  (rd_re1),
      .rd_imag  (rd_im1)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_IDLE;
         wait_first <= 1'b0;
         fill_sel   <= 1'b0;
         wr_idx     <= '0;
         s_ready    <= 1'b0;
         fft_write  <= 1'b0;
         fft_start  <= 1'b0;
         frame_cnt  <= '0;
         frame_real <= '0;
         frame_imag <= '0;
      end else begin
         if (swap)                    s_ready <= fill_sel ? !full0 : !full1;
         else if (last || flush_eff)  s_ready <= 1'b0;
         else                         s_ready <= !fill_full;

         if (flush_eff)   wr_idx <= '0;
         else if (accept) wr_idx <= wr_idx + 1'b1;

         case (state)
            ST_IDLE: begin
               if (fill_full) begin
                  state      <= ST_WRITE;
                  fft_write  <= 1'b1;
                  fill_sel   <= ~fill_sel;
                  frame_real <= fill_sel ? rd_re1 : rd_re0;
                  frame_imag <= fill_sel ? rd_im1 : rd_im0;
               end
            end
            ST_WRITE: begin
               fft_write <= 1'b0;
               fft_start <= 1'b1;
               frame_cnt <= frame_cnt + 16'd1;
               state     <= ST_START;
            end
            ST_START: begin
               fft_start  <= 1'b0;
               wait_first <= 1'b1;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               // The FFT's ready may still reflect the previous frame in the first WAIT cycle.
               if (wait_first)     wait_first <= 1'b0;
               else if (fft_ready) state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
